// File: rtl/gray_counter_if.sv
// Gray counter control/result bundle.
//   master: drives en, up, load, load_b; observes b, g, flip, wrap
//   slave : the counter itself
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] flip;
  logic             wrap;

  modport master (
    output en, up, load, load_b,
    input  b, g, flip, wrap
  );

  modport slave (
    input  en, up, load, load_b,
    output b, g, flip, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered binary up/down counter with a matching reflected-binary Gray output.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - gray_counter_if.slave: en/up/load/load_b in; b/g/flip/wrap out (all registered)
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] flip_q, flip_d;
  logic             wrap_q, wrap_d;

  // Next state: load beats step beats hold; pulses default to 0.
  always_comb begin
    b_d    = b_q;
    g_d    = g_q;
    flip_d = '0;
    wrap_d = 1'b0;
    if (bus.load) begin
      b_d = bus.load_b;
      g_d = bus.load_b ^ (bus.load_b >> 1);
    end else if (bus.en) begin
      if (bus.up) begin
        b_d    = b_q + ONE;
        wrap_d = (b_q == ALL_ONES);
      end else begin
        b_d    = b_q - ONE;
        wrap_d = (b_q == '0);
      end
      g_d    = b_d ^ (b_d >> 1);
      // A unit step changes exactly one Gray bit, so this is one-hot.
      flip_d = g_q ^ g_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      g_q    <= '0;
      flip_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      flip_q <= flip_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.b    = b_q;
  assign bus.g    = g_q;
  assign bus.flip = flip_q;
  assign bus.wrap = wrap_q;

endmodule

// File: doc/gray_counter.md
# gray_counter

Registered binary-to-Gray up/down counter: the encoding end of the Gray-code path whose decoder turns `g` back into binary `b`. It keeps a binary count and registers the matching reflected-binary Gray code `b ^ (b >> 1)`. Between any two consecutive counts exactly one Gray bit changes. It sources Gray-coded pointers and positions for downstream decode logic. It also exports a one-hot flag showing which Gray bit toggled on each step.

## Interface

- `WIDTH`, default 4, width of the count, Gray output and flip vector (>= 2).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable; one step per cycle while high.
- `up` input 1: direction; 1 = increment, 0 = decrement; sampled only when a step occurs.
- `load` input 1: synchronous load of `load_b`; has priority over `en`.
- `load_b` input WIDTH: binary value to load.
- `b` output WIDTH: registered binary count.
- `g` output WIDTH: registered Gray code, always equal to `b ^ (b >> 1)`.
- `flip` output WIDTH: registered one-hot index of the Gray bit changed by the last step; 0 otherwise.
- `wrap` output 1: registered; 1 for one cycle after a step that crossed the end of the range.

## Operation

- The next state is chosen with this priority: reset, then load, then step, then hold.
- **Reset (`rst_n` = 0)**, immediate and asynchronous:
  - `b`, `g`, `flip` = 0.
  - `wrap` = 0.
  - Reset held through edges: no loads or steps take effect.
- **Load (`load` = 1)**:
  - `b` <= `load_b`.
  - `g` <= `load_b ^ (load_b >> 1)`.
  - `flip` <= 0 and `wrap` <= 0, even if `load_b` differs from `b` in several Gray bits.
  - `en` and `up` are ignored.
- **Step (`load` = 0, `en` = 1)**:
  - `up` = 1: `b` <= (`b` + 1) mod 2^WIDTH; `wrap` <= 1 iff `b` was all-ones.
  - `up` = 0: `b` <= (`b` - 1) mod 2^WIDTH; `wrap` <= 1 iff `b` was 0.
  - `g` <= Gray of the new `b`.
  - `flip` <= old `g` XOR new `g`, which is one-hot by construction.
- **Hold (`load` = 0, `en` = 0)**:
  - `b` and `g` are unchanged.
  - `flip` <= 0 and `wrap` <= 0.
- **Arithmetic**: unsigned modulo 2^WIDTH with no saturation. The carry/borrow out goes only to `wrap`.
- **Gray encoding**: `g[WIDTH-1]` = `b[WIDTH-1]`; `g[i]` = `b[i+1] ^ b[i]` for i < WIDTH-1.
- **Outputs are registered**: there is no combinational path from any input to any output.
- **Direction changes**: `up` may change on any cycle. Reversing direction gives the same Gray bit back, so `flip` repeats the previous index.

## Timing

- Latency is 1 cycle. A load or step sampled at edge N is visible on `b`, `g`, `flip` and `wrap` after edge N.
- Throughput is one step per cycle. Holding `en` high for 2^WIDTH cycles returns to the start value with exactly one `wrap` pulse.
- `flip` and `wrap` are single-cycle pulses tied to the step that produced them. Consecutive steps give back-to-back values with no bubble.
- **Reset released mid-count**: the first edge with `rst_n` = 1 evaluates the inputs normally from state 0.
- **`load` and `en` high together**: the load wins, and no `wrap` or `flip` is produced.

## Test plan

- **Reset**: assert `rst_n` = 0 mid-count from `b` = 9 -> `b`, `g`, `flip` = 0 and `wrap` = 0 with no clock edge. Hold reset for 3 edges with `en` = 1 -> values stay 0.
- **Count up**: `en` = 1, `up` = 1, WIDTH = 4 for 16 cycles from reset.
  - `g` must run 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - `flip` is one-hot on every cycle; the last step gives `flip` = 1000.
  - `wrap` = 1 only on the final cycle.
- **Count down**: from 0, `up` = 0, one step -> `b` = 1111, `g` = 1000, `flip` = 1000, `wrap` = 1. The next step gives `b` = 1110, `g` = 1001, `flip` = 0001, `wrap` = 0.
- **Load**: `load` = 1, `load_b` = 1010 -> `b` = 1010, `g` = 1111, `flip` = 0, `wrap` = 0. Repeat with `en` = 1 in the same cycle -> identical result.
- **Hold and reversal**: from `b` = 0101, step up (`g` 0111 -> 0101, `flip` = 0010), hold one cycle (`flip` = 0, `g` stays 0101), step down (`g` = 0111, `flip` = 0010).
- **Random**: 10k cycles of random `en`, `up`, `load` and `load_b`, checked against a reference model.
  - Every cycle: `g` == `b ^ (b >> 1)`.
  - After every step: `flip` popcount is 1.
  - `wrap` matches the model's carry/borrow.
